mbssoc_mem_responder: RTL and testbench



---
 rtl/mbssoc_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_mbssoc_mem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbssoc_mem_responder.sv
// ---------------------------------------------------------------------------
// mbssoc_mem_responder
// Slave-side responder for the shared SoC memory bus. Accepts one granted
// request from the bus controller, runs it against a synchronous single-port
// SRAM after a configurable number of wait states, and returns a one-cycle
// ack carrying read data or an error flag.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   req_re/we     - read / write request (both set is an error)
//   req_addr      - byte address, must be word aligned and inside the window
//   req_wdata     - write data
//   req_id        - requesting core (0=CPU0, 1=CPU1)
//   busy          - responder not idle; new requests are ignored
//   ack           - one-cycle completion pulse
//   ack_id        - req_id of the completed request
//   ack_err       - completion is an error
//   rdata         - read data, valid while ack=1, otherwise 0
//   sram_*        - synchronous SRAM macro interface (word addressed)
// ---------------------------------------------------------------------------
module mbssoc_mem_responder #(
    parameter int                      DATA_WIDTH = 32,
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      MEM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h0000_0000,
    parameter int                      RD_WAIT    = 1,
    parameter int                      WR_WAIT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_re,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_id,
    output logic                  busy,
    output logic                  ack,
    output logic                  ack_id,
    output logic                  ack_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [MEM_AW-1:0]     sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);
    localparam logic [3:0] WR_WAIT_C = 4'(WR_WAIT);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_id;
    logic                  r_is_read;
    logic                  r_ack;
    logic                  r_ack_id;
    logic                  r_ack_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_sram_en;
    logic                  r_sram_we;
    logic [MEM_AW-1:0]     r_sram_addr;
    logic [DATA_WIDTH-1:0] r_sram_wdata;

    logic w_req;
    logic w_err_both;
    logic w_err_align;
    logic w_err_window;
    logic w_err;

    // Request qualification and accept-time error decode
    always_comb begin
        w_req        = req_re | req_we;
        w_err_both   = req_re & req_we;
        w_err_align  = (req_addr[1:0] != 2'b00);
        // Only the bits above the SRAM window select the window itself
        w_err_window = (req_addr[ADDR_WIDTH-1:MEM_AW+2] != BASE_ADDR[ADDR_WIDTH-1:MEM_AW+2]);
        w_err        = w_err_both | w_err_align | w_err_window;
    end

    // Responder FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_id         <= 1'b0;
            r_is_read    <= 1'b0;
            r_ack        <= 1'b0;
            r_ack_id     <= 1'b0;
            r_ack_err    <= 1'b0;
            r_rdata      <= '0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack     <= 1'b0;
                    r_ack_err <= 1'b0;
                    r_rdata   <= '0;
                    if (w_req) begin
                        r_id      <= req_id;
                        r_is_read <= req_re & ~req_we;
                        if (w_err) begin
                            // Rejected requests skip the SRAM and ack next cycle
                            r_state   <= ST_RESP;
                            r_ack     <= 1'b1;
                            r_ack_id  <= req_id;
                            r_ack_err <= 1'b1;
                        end else begin
                            // Strobe is issued in the first ACCESS cycle
                            r_state      <= ST_ACCESS;
                            r_sram_en    <= 1'b1;
                            r_sram_we    <= req_we;
                            r_sram_addr  <= req_addr[MEM_AW+1:2];
                            r_sram_wdata <= req_wdata;
                            r_cnt        <= req_re ? RD_WAIT_C : WR_WAIT_C;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_sram_en <= 1'b0;
                    r_sram_we <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        // SRAM data is valid on this edge, one cycle after the strobe
                        r_state   <= ST_RESP;
                        r_ack     <= 1'b1;
                        r_ack_id  <= r_id;
                        r_ack_err <= 1'b0;
                        r_rdata   <= r_is_read ? sram_rdata : '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_ack     <= 1'b0;
                    r_ack_id  <= 1'b0;
                    r_ack_err <= 1'b0;
                    r_rdata   <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ack     <= 1'b0;
                    r_ack_err <= 1'b0;
                    r_rdata   <= '0;
                    r_sram_en <= 1'b0;
                    r_sram_we <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign ack        = r_ack;
    assign ack_id     = r_ack_id;
    assign ack_err    = r_ack_err;
    assign rdata      = r_rdata;
    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_mbssoc_mem_responder.sv
module tb_mbssoc_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        req_re, req_we, req_id;
    logic [31:0] req_addr, req_wdata;

    // DUT A: RD_WAIT=1, WR_WAIT=0
    logic        a_busy, a_ack, a_ack_id, a_ack_err, a_sram_en, a_sram_we;
    logic [31:0] a_rdata, a_sram_wdata, a_sram_rdata;
    logic [9:0]  a_sram_addr;
    // DUT B: RD_WAIT=3, WR_WAIT=0
    logic        b_busy, b_ack, b_ack_id, b_ack_err, b_sram_en, b_sram_we;
    logic [31:0] b_rdata, b_sram_wdata, b_sram_rdata;
    logic [9:0]  b_sram_addr;

    mbssoc_mem_responder #(.RD_WAIT(1), .WR_WAIT(0)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_re(req_re), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .busy(a_busy), .ack(a_ack), .ack_id(a_ack_id), .ack_err(a_ack_err),
        .rdata(a_rdata), .sram_en(a_sram_en), .sram_we(a_sram_we),
        .sram_addr(a_sram_addr), .sram_wdata(a_sram_wdata), .sram_rdata(a_sram_rdata)
    );

    mbssoc_mem_responder #(.RD_WAIT(3), .WR_WAIT(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_re(req_re), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .busy(b_busy), .ack(b_ack), .ack_id(b_ack_id), .ack_err(b_ack_err),
        .rdata(b_rdata), .sram_en(b_sram_en), .sram_we(b_sram_we),
        .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_rdata(b_sram_rdata)
    );

    // Synchronous SRAM models: read data appears the cycle after the strobe
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    always @(posedge clk) begin
        if (a_sram_en) begin
            if (a_sram_we) mem_a[a_sram_addr] <= a_sram_wdata;
            else           a_sram_rdata <= mem_a[a_sram_addr];
        end
        if (b_sram_en) begin
            if (b_sram_we) mem_b[b_sram_addr] <= b_sram_wdata;
            else           b_sram_rdata <= mem_b[b_sram_addr];
        end
    end

    // Observed DUT selected by cur (0=A, 1=B)
    logic cur;
    wire        o_busy      = cur ? b_busy      : a_busy;
    wire        o_ack       = cur ? b_ack       : a_ack;
    wire        o_ack_id    = cur ? b_ack_id    : a_ack_id;
    wire        o_ack_err   = cur ? b_ack_err   : a_ack_err;
    wire [31:0] o_rdata     = cur ? b_rdata     : a_rdata;
    wire        o_sram_en   = cur ? b_sram_en   : a_sram_en;
    wire        o_sram_we   = cur ? b_sram_we   : a_sram_we;
    wire [9:0]  o_sram_addr = cur ? b_sram_addr : a_sram_addr;
    wire [31:0] o_sram_wdata = cur ? b_sram_wdata : a_sram_wdata;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic id);
        req_re    = re;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_id    = id;
    endtask

    task automatic push_exp(input logic id, input logic err, input logic [31:0] rd);
        exp_t e;
        e.id    = id;
        e.err   = err;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " ack_id"},  {31'd0, o_ack_id},  {31'd0, e.id});
            check({tag, " ack_err"}, {31'd0, o_ack_err}, {31'd0, e.err});
            check({tag, " rdata"},   o_rdata,            e.rdata);
        end
    endtask

    // One full access: drive, wait (bounded) for ack, compare latency/response
    task automatic do_access(input string tag, input logic re, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic id, input int exp_lat, input logic exp_err,
                             input logic [31:0] exp_rd);
        int  lat;
        int  strobes;
        bit  got;
        push_exp(id, exp_err, exp_rd);
        drive(re, we, addr, wdata, id);
        got = 1'b0; lat = 0; strobes = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (o_sram_en === 1'b1) strobes++;
            if (o_ack === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
        check({tag, " ack seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, " latency"}, lat, exp_lat);
            check_resp(tag);
        end else begin
            void'(sb.pop_front());
        end
        check({tag, " strobes"}, strobes, exp_err ? 32'd0 : 32'd1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        check({tag, " ack width"}, {31'd0, o_ack}, 32'd0);
        check({tag, " idle after"}, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        cur   = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();

        // Reset state of both instances
        for (int d = 0; d < 2; d++) begin
            cur = d[0];
            check("rst busy",       {31'd0, o_busy},    32'd0);
            check("rst ack",        {31'd0, o_ack},     32'd0);
            check("rst ack_id",     {31'd0, o_ack_id},  32'd0);
            check("rst ack_err",    {31'd0, o_ack_err}, 32'd0);
            check("rst sram_en",    {31'd0, o_sram_en}, 32'd0);
            check("rst sram_we",    {31'd0, o_sram_we}, 32'd0);
            check("rst rdata",      o_rdata,            32'd0);
            check("rst sram_addr",  {22'd0, o_sram_addr}, 32'd0);
            check("rst sram_wdata", o_sram_wdata,       32'd0);
        end
        cur   = 1'b0;
        rst_a = 1'b0;
        tick();
        check("idle busy", {31'd0, o_busy}, 32'd0);

        // Write 0x10 <- DEADBEEF, id 1, cycle by cycle
        push_exp(1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        tick();
        check("wr c1 sram_en",    {31'd0, o_sram_en}, 32'd1);
        check("wr c1 sram_we",    {31'd0, o_sram_we}, 32'd1);
        check("wr c1 sram_addr",  {22'd0, o_sram_addr}, 32'd4);
        check("wr c1 sram_wdata", o_sram_wdata, 32'hDEAD_BEEF);
        check("wr c1 busy",       {31'd0, o_busy}, 32'd1);
        check("wr c1 ack",        {31'd0, o_ack}, 32'd0);
        tick();
        check("wr c2 ack",     {31'd0, o_ack}, 32'd1);
        check("wr c2 sram_en", {31'd0, o_sram_en}, 32'd0);
        check_resp("wr c2");
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        check("wr c3 ack",  {31'd0, o_ack}, 32'd0);
        check("wr c3 busy", {31'd0, o_busy}, 32'd0);

        do_access("rd 0x10", 1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 3, 1'b0, 32'hDEAD_BEEF);

        // Error cases: ack in cycle 1, no strobe, rdata 0
        do_access("err both",   1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b1, 1, 1'b1, 32'd0);
        do_access("err align",  1'b1, 1'b0, 32'h0000_0013, 32'd0,          1'b0, 1, 1'b1, 32'd0);
        do_access("err window", 1'b1, 1'b0, 32'h0000_1000, 32'd0,          1'b1, 1, 1'b1, 32'd0);
        do_access("err wr win", 1'b0, 1'b1, 32'h8000_0000, 32'h2222_2222, 1'b0, 1, 1'b1, 32'd0);

        // Last word of the window
        do_access("wr top", 1'b0, 1'b1, 32'h0000_0FFC, 32'hA5A5_0F0F, 1'b0, 2, 1'b0, 32'd0);
        do_access("rd top", 1'b1, 1'b0, 32'h0000_0FFC, 32'd0,          1'b1, 3, 1'b0, 32'hA5A5_0F0F);

        // Held request across ack, then a new request held through RESP
        push_exp(1'b1, 1'b0, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
        tick();
        tick();
        tick();
        check("hold c3 ack", {31'd0, o_ack}, 32'd1);
        check_resp("hold c3");
        push_exp(1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0);
        tick();
        check("hold c4 ack",     {31'd0, o_ack},     32'd0);
        check("hold c4 busy",    {31'd0, o_busy},    32'd0);
        check("hold c4 sram_en", {31'd0, o_sram_en}, 32'd0);
        tick();
        check("hold c5 sram_en",   {31'd0, o_sram_en}, 32'd1);
        check("hold c5 sram_we",   {31'd0, o_sram_we}, 32'd1);
        check("hold c5 sram_addr", {22'd0, o_sram_addr}, 32'd8);
        check("hold c5 ack",       {31'd0, o_ack}, 32'd0);
        tick();
        check("hold c6 ack", {31'd0, o_ack}, 32'd1);
        check_resp("hold c6");
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        check("hold c7 ack",  {31'd0, o_ack},  32'd0);
        check("hold c7 busy", {31'd0, o_busy}, 32'd0);

        // Switch to instance B (RD_WAIT=3)
        rst_a = 1'b1;
        rst_b = 1'b0;
        cur   = 1'b1;
        tick();
        do_access("b wr 0x0", 1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 2, 1'b0, 32'd0);

        push_exp(1'b0, 1'b0, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("ws c%0d busy", c),    {31'd0, o_busy},    (c <= 5) ? 32'd1 : 32'd0);
            check($sformatf("ws c%0d sram_en", c), {31'd0, o_sram_en}, (c == 1) ? 32'd1 : 32'd0);
            check($sformatf("ws c%0d ack", c),     {31'd0, o_ack},     (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) begin
                check_resp("ws c5");
                drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            end
        end

        // Reset in the second ACCESS cycle of a read: no ack, back to idle
        drive(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b1);
        tick();
        tick();
        check("mid c2 busy", {31'd0, o_busy}, 32'd1);
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        check("mid c3 busy",    {31'd0, o_busy},    32'd0);
        check("mid c3 ack",     {31'd0, o_ack},     32'd0);
        check("mid c3 sram_en", {31'd0, o_sram_en}, 32'd0);
        check("mid c3 addr",    {22'd0, o_sram_addr}, 32'd0);
        check("mid c3 rdata",   o_rdata,            32'd0);
        rst_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid no ack", {31'd0, o_ack}, 32'd0);
        end
        do_access("b rd after rst", 1'b1, 1'b0, 32'h0000_0000, 32'd0, 1'b1, 5, 1'b0, 32'hCAFE_F00D);

        check("scoreboard drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
